// File: rtl/tone_period_meter.sv
// Half-period meter for a synchronous square wave: reports each interval between
// input edges, flags lock when consecutive intervals agree, and times out on a stuck input.
module tone_period_meter #(
  parameter int   PERIOD_BITS = 12,
  parameter logic RESET_LEVEL = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tone_in,
  output logic [PERIOD_BITS-1:0] period,
  output logic                   period_strobe,
  output logic                   period_valid,
  output logic                   timeout
);

  localparam logic [PERIOD_BITS-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    TRACK
  } state_t;

  state_t                   state, state_next;
  logic                     prev;
  logic [PERIOD_BITS-1:0]   cnt;
  logic                     tone_edge;
  logic                     cnt_sat;
  logic [PERIOD_BITS-1:0]   period_next;
  logic                     strobe_next;
  logic                     valid_next;
  logic                     timeout_next;

  assign tone_edge = tone_in ^ prev;
  assign cnt_sat   = (cnt == CNT_MAX);

  // prev starts at the generator's reset level so a meter and generator released
  // together do not see a spurious edge.
  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev <= RESET_LEVEL;
      cnt  <= '0;
    end else begin
      prev <= tone_in;
      if (tone_edge)     cnt <= {{(PERIOD_BITS-1){1'b0}}, 1'b1};
      else if (!cnt_sat) cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      period        <= '0;
      period_strobe <= 1'b0;
      period_valid  <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      state         <= state_next;
      period        <= period_next;
      period_strobe <= strobe_next;
      period_valid  <= valid_next;
      timeout       <= timeout_next;
    end
  end

  // NOTE: every output of this block gets a hold/default value first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next   = state;
    period_next  = period;
    strobe_next  = 1'b0;
    valid_next   = period_valid;
    timeout_next = timeout;

    case (state)
      IDLE: begin
        if (tone_edge) begin
          state_next   = FIRST;
          timeout_next = 1'b0;
        end
      end
      FIRST, TRACK: begin
        // An edge coinciding with saturation is a valid maximum-length interval.
        if (tone_edge) begin
          state_next  = TRACK;
          period_next = cnt;
          strobe_next = 1'b1;
          valid_next  = (state == TRACK) && (cnt == period);
        end else if (cnt_sat) begin
          state_next   = IDLE;
          timeout_next = 1'b1;
          valid_next   = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
